// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling and mid-bit
// sampling, feeding a small show-ahead FIFO. Framing errors and FIFO
// overruns are reported as sticky flags cleared by clr_err.
module uart_rx_fifo #(
    parameter int DIV   = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     rx_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     frame_err,
    output logic                     overrun,
    input  logic                     clr_err
);

    localparam int              AW   = $clog2(DEPTH);
    localparam logic [15:0]     TMAX = 16'(DIV - 1);
    localparam logic [AW:0]     FULL = (AW + 1)'(DEPTH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    logic        s1, s2;
    logic        rxs;
    logic [15:0] tcnt;
    logic        tick;
    logic [2:0]  state;
    logic [3:0]  sc;
    logic [2:0]  bidx;
    logic [7:0]  shreg;
    logic        stop_smp;
    logic        push;
    logic        ferr_set;

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    logic        full;
    logic        do_pop;
    logic        do_push;
    logic        ovr_set;

    // Two-flop synchronizer for the asynchronous serial pin; idles high.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= rx;
            s2 <= s1;
        end
    end

    assign rxs = s2;

    // Free-running oversample tick divider: one tick every DIV clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 16'd1;
        end
    end

    assign tick = (tcnt == TMAX);

    // Receive FSM: start qualification, data shifting, stop check, break wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sc    <= '0;
            bidx  <= '0;
            shreg <= '0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        sc    <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (sc == 4'd7) begin
                        if (!rxs) begin
                            sc    <= '0;
                            bidx  <= '0;
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        sc <= sc + 4'd1;
                    end
                end
                DATA: begin
                    sc <= sc + 4'd1;
                    if (sc == 4'd15) begin
                        shreg <= {rxs, shreg[7:1]};
                        bidx  <= bidx + 3'd1;
                        if (bidx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    sc <= sc + 4'd1;
                    if (sc == 4'd15) begin
                        state <= rxs ? IDLE : BREAK;
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The stop-bit sample either delivers the byte or flags a framing error.
    assign stop_smp = tick && (state == STOP) && (sc == 4'd15);
    assign push     = stop_smp && rxs;
    assign ferr_set = stop_smp && !rxs;

    // A pop at full frees the slot that a simultaneous push then uses.
    assign full    = (count == FULL);
    assign do_pop  = rd_en && (count != '0);
    assign do_push = push && (!full || do_pop);
    assign ovr_set = push && full && !do_pop;

    // FIFO storage write port.
    // NOTE: the storage array has no reset; only pointers and count do,
    // and rd_data is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= shreg;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set || (frame_err && !clr_err);
            overrun   <= ovr_set  || (overrun   && !clr_err);
        end
    end

    // Show-ahead read port: head entry, or zero when empty.
    // NOTE: the default assignment first keeps this purely combinational.
    always_comb begin
        rd_data = 8'h00;
        if (count != '0) begin
            rd_data = mem[rptr];
        end
    end

    assign rx_valid = (count != '0);
    assign level    = count;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

- Receives 8N1 serial bytes from the board's `uart_rx` pin and buffers them in a small show-ahead FIFO.
- Its output is read by the MIPS core's memory-mapped UART register logic, so it sits directly upstream of the processor's load path on the receive side.
- Uses 16x oversampling with mid-bit sampling, and flags framing errors and FIFO overruns as sticky status.

## Interface

Parameters:
- `DIV`, 65: clk cycles per oversample tick. 65 gives 9600 baud at 10 MHz. Legal range 1..65535.
- `DEPTH`, 4: FIFO entries. Power of two, at least 2.

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rx` in 1: serial input. Asynchronous to `clk`; idles high.
- `rd_en` in 1: pops the FIFO head. Ignored when the FIFO is empty.
- `rd_data` out 8: FIFO head, show-ahead. 0x00 when empty.
- `rx_valid` out 1: FIFO not empty.
- `level` out clog2(DEPTH)+1: FIFO occupancy.
- `frame_err` out 1: sticky. Set when a stop bit is sampled low.
- `overrun` out 1: sticky. Set when a byte is dropped because the FIFO is full.
- `clr_err` in 1: clears `frame_err` and `overrun`.

## Operation

Reset:
- Outputs: `rd_data`=0x00, `rx_valid`=0, `level`=0, `frame_err`=0, `overrun`=0.
- Internal: synchronizer flops=1, state=IDLE, tick and sample counters=0.

Input path and tick generation:
- `rx` passes through a 2-flop synchronizer; only the synchronized value is used.
- Tick counter counts 0..DIV-1 and pulses `tick` for one clk when it equals DIV-1. It is free-running.
- Sample counter `sc` (4 bits) advances only on `tick`.

FSM, all transitions evaluated on `tick`:
- IDLE: if synchronized rx=0, then `sc`<=0 and go to START.
- START: at `sc`=7 (mid start bit), if rx=0 then `sc`<=0, bit index<=0, go to DATA. If rx=1, treat as a glitch and return to IDLE.
- DATA: at `sc`=15, shift rx into the shift register LSB-first. After the 8th bit go to STOP.
- STOP: at `sc`=15 (mid stop bit):
  - rx=1: push the byte and go to IDLE.
  - rx=0: set `frame_err`, discard the byte, go to BREAK.
- BREAK: wait for rx=1, then go to IDLE. This prevents a held-low line from producing repeated frames.

FIFO:
- Circular buffer with wrap-around read/write pointers and an occupancy counter.
- Push while full drops the new byte and sets `overrun`; FIFO contents are unchanged.
- Push and pop in the same cycle:
  - Full: the pop frees a slot, the push is accepted, `overrun` is not set, `level` is unchanged.
  - Empty: only the push takes effect.
- `rd_en` while empty has no effect.

Error flags:
- `clr_err` in the same cycle as a new error event: the set wins and the flag is 1 next cycle.
- `clr_err` does not touch FIFO contents.

Reset mid-frame aborts the frame immediately. After reset release, the FSM resynchronizes on the next falling edge seen in IDLE.

## Timing

- Synchronizer latency: 2 clk from a pin edge to the internal signal.
- Start detection: within one tick (up to DIV clk) of the synchronized falling edge.
- Bit period is 16 ticks. The first data bit is sampled 24 ticks (±1) after start detection.
- On the clk after the stop-bit sample: `rx_valid`=1, `level` has incremented, `rd_data` shows the byte if the FIFO was previously empty.
- `rd_en` at edge N:
  - `rd_data` shows the next entry at N+1.
  - `rx_valid` falls at N+1 if that pop emptied the FIFO.
- Flag timing: `frame_err` and `overrun` assert 1 clk after the offending sample; `clr_err` takes effect at the next edge.
- Back-to-back frames: a start bit immediately following the stop bit is accepted. IDLE re-enters at the stop-bit mid-sample, so there is ≥8 ticks of margin.

## Test plan

All scenarios use DIV=1, so one bit is 16 clk.
- Single byte: drive 0xA5 8N1. `rx_valid` rises ~ (2 + 1 + 8 + 16×9) clk after the start edge; `rd_data`=0xA5, `level`=1. Pulse `rd_en` → `rx_valid`=0, `level`=0.
- Glitch rejection: pulse `rx` low for 4 clk only → FSM returns to IDLE, no push, no error flags.
- Framing error: send 0x3C with the stop bit held low, release high 32 clk later → `frame_err`=1, `level`=0. Then send 0x55 → received correctly. `clr_err` → `frame_err`=0.
- Overrun: send 0x01..0x05 without reading (DEPTH=4) → `level`=4, `overrun`=1. Reads return 0x01..0x04 in order, with pointer wrap covered.
- Simultaneous pop at full: FIFO full, assert `rd_en` on the push cycle of 0x77 → `overrun` stays 0, `level` stays 4, 0x77 is read last.
- Reset mid-frame: assert `rst` during data bit 3 → all outputs at reset values. A following 0xC3 frame is received correctly.
